truth_table_sweeper: RTL and testbench
======================================

TRUTH_TABLE_SWEEPER -- requirements
Module: truth_table_sweeper

Interface
REQ-001 Parameter SETTLE, default 1, meaning: cycles each input vector is held before s_in is sampled (legal range 1..15).
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request a full 16-vector sweep; accepted only in IDLE.
REQ-005 expected  input  16  expected function output; bit i = expected s for vector i = {x,y,w,z}, with x as MSB.
REQ-006 s_in  input  1  output of the 4-input combinational function under test.
REQ-007 x, y, w, z  output  1 each  drive the function under test; {x,y,w,z} = current vector index.
REQ-008 busy  output  1  high while a sweep is in progress.
REQ-009 done  output  1  one-cycle pulse when a sweep completes.
REQ-010 pass  output  1  high when the last completed sweep had zero mismatches.
REQ-011 err_count  output  5  number of mismatches in the last sweep, 0..16.
REQ-012 first_err  output  4  index of the lowest-indexed mismatching vector.
REQ-013 first_err_valid  output  1  first_err is meaningful (at least one mismatch).

Function
REQ-014 The FSM SHALL have four states: IDLE, DRIVE, SAMPLE, DONE.
REQ-015 IDLE: when start=1 at a rising edge, the block SHALL latch expected into an internal register, set idx=0, clear err_count, pass, first_err and first_err_valid, and enter DRIVE.
REQ-016 DRIVE: {x,y,w,z} SHALL equal idx; the FSM SHALL stay in DRIVE for exactly SETTLE cycles, then enter SAMPLE.
REQ-017 SAMPLE: {x,y,w,z} SHALL still equal idx; at the closing edge the block SHALL compare s_in with exp_reg[idx].
REQ-018 On a mismatch: err_count SHALL increment by 1; if first_err_valid=0, first_err SHALL load idx and first_err_valid SHALL be set.
REQ-019 After SAMPLE: if idx=15 the FSM SHALL enter DONE; otherwise idx SHALL increment by 1 and the FSM SHALL enter DRIVE.
REQ-020 idx SHALL be 4 bits and SHALL never wrap; leaving SAMPLE with idx=15 is the only exit to DONE.
REQ-021 err_count SHALL be 5 bits so that it holds 16 without overflow.
REQ-022 DONE: done=1 and pass=(err_count==0) for exactly one cycle; the FSM SHALL then return to IDLE.
REQ-023 pass, err_count, first_err and first_err_valid SHALL hold their values in IDLE until the next accepted start.
REQ-024 busy SHALL be 1 in DRIVE and SAMPLE, and 0 in IDLE and DONE.
REQ-025 {x,y,w,z} SHALL be 0000 in IDLE and DONE.
REQ-026 start SHALL be ignored in DRIVE, SAMPLE and DONE, and SHALL not be queued.
REQ-027 Changes on expected after acceptance SHALL NOT affect the running sweep.
REQ-028 Latency: with start accepted at cycle 0, vector k SHALL be sampled at the end of cycle 1+k*(SETTLE+1)+SETTLE, and done SHALL pulse in cycle 16*(SETTLE+1)+1 (cycle 33 for SETTLE=1).
REQ-029 The block SHALL contain no combinational path from s_in to any output.

Reset
REQ-030 When rst_n=0, the block SHALL immediately, without waiting for clk, enter IDLE with the following outputs and internal state:
- x, y, w, z, busy, done, pass, first_err_valid = 0
- err_count = 0, first_err = 0
- idx = 0, exp_reg = 0
REQ-031 Reset during a sweep SHALL abort it; done SHALL NOT pulse for the aborted sweep.
REQ-032 The first start SHALL be accepted at the first rising edge after rst_n deasserts.

Verification
REQ-033 Reset: apply rst_n=0 between clock edges -> every output is 0 at once; busy stays 0 with start=0.
REQ-034 SETTLE=1, s_in=x, expected=16'hFF00, pulse start at cycle 0 -> done at cycle 33, pass=1, err_count=0, first_err_valid=0.
REQ-035 s_in=x, expected=16'hFF01 -> err_count=1, first_err=0, first_err_valid=1, pass=0.
REQ-036 s_in=0, expected=16'h8000 -> err_count=1, first_err=15; a further sweep with expected=16'hFFFF gives err_count=16, first_err=0.
REQ-037 Start held high for the whole sweep -> exactly one done pulse; the next sweep starts only on the edge after DONE returns to IDLE; a mid-sweep change of expected to 16'h0000 has no effect on the result.
REQ-038 rst_n pulsed low while idx=7 -> outputs 0 at once, no done pulse; a new start gives the normal cycle-33 completion.

Source files
------------

// File: rtl/truth_table_sweeper.sv
// rtl/truth_table_sweeper.sv - exhaustive 16-vector sweep of a 4-input function against an expected truth table
`timescale 1ns/1ps

module truth_table_sweeper #(
  parameter int SETTLE = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] expected,
  input  logic        s_in,
  output logic        x,
  output logic        y,
  output logic        w,
  output logic        z,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [4:0]  err_count,
  output logic [3:0]  first_err,
  output logic        first_err_valid
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRIVE,
    S_SAMPLE,
    S_DONE
  } state_t;

  // Last value of the settle counter before moving on to SAMPLE.
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  state_t      r_state;
  logic [15:0] r_exp;
  logic [3:0]  r_idx;
  logic [3:0]  r_settle;
  logic [3:0]  r_vec;
  logic        r_busy;
  logic        r_done;
  logic        r_pass;
  logic [4:0]  r_err_count;
  logic [3:0]  r_first_err;
  logic        r_first_err_valid;

  logic        w_mismatch;
  logic [4:0]  w_err_next;

  // Mismatch is only consumed at the SAMPLE closing edge, so s_in never reaches an output combinationally.
  assign w_mismatch = (s_in != r_exp[r_idx]);
  assign w_err_next = r_err_count + {4'd0, w_mismatch};

  // Sweep controller: every output is a register updated here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state           <= S_IDLE;
      r_exp             <= 16'd0;
      r_idx             <= 4'd0;
      r_settle          <= 4'd0;
      r_vec             <= 4'd0;
      r_busy            <= 1'b0;
      r_done            <= 1'b0;
      r_pass            <= 1'b0;
      r_err_count       <= 5'd0;
      r_first_err       <= 4'd0;
      r_first_err_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_exp             <= expected;
            r_idx             <= 4'd0;
            r_settle          <= 4'd0;
            r_vec             <= 4'd0;
            r_busy            <= 1'b1;
            r_pass            <= 1'b0;
            r_err_count       <= 5'd0;
            r_first_err       <= 4'd0;
            r_first_err_valid <= 1'b0;
            r_state           <= S_DRIVE;
          end
        end
        S_DRIVE: begin
          if (r_settle == SETTLE_LAST) begin
            r_state <= S_SAMPLE;
          end else begin
            r_settle <= r_settle + 4'd1;
          end
        end
        S_SAMPLE: begin
          r_err_count <= w_err_next;
          if (w_mismatch && !r_first_err_valid) begin
            r_first_err       <= r_idx;
            r_first_err_valid <= 1'b1;
          end
          if (r_idx == 4'd15) begin
            // Final vector: pass must reflect this sample's mismatch too, hence w_err_next.
            r_busy  <= 1'b0;
            r_vec   <= 4'd0;
            r_done  <= 1'b1;
            r_pass  <= (w_err_next == 5'd0);
            r_state <= S_DONE;
          end else begin
            r_idx    <= r_idx + 4'd1;
            r_vec    <= r_idx + 4'd1;
            r_settle <= 4'd0;
            r_state  <= S_DRIVE;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign {x, y, w, z}    = r_vec;
  assign busy            = r_busy;
  assign done            = r_done;
  assign pass            = r_pass;
  assign err_count       = r_err_count;
  assign first_err       = r_first_err;
  assign first_err_valid = r_first_err_valid;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb/tb_truth_table_sweeper.sv - randomized self-checking bench for truth_table_sweeper
`timescale 1ns/1ps

module tb_truth_table_sweeper;

  localparam int SETTLE = 1;
  localparam int DONE_CYCLE = 16 * (SETTLE + 1) + 1;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] expected;
  logic        s_in;
  logic        x, y, w, z;
  logic        busy, done, pass;
  logic [4:0]  err_count;
  logic [3:0]  first_err;
  logic        first_err_valid;

  logic [15:0] tt;

  int n_pass  = 0;
  int n_total = 0;

  truth_table_sweeper #(.SETTLE(SETTLE)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .expected        (expected),
    .s_in            (s_in),
    .x               (x),
    .y               (y),
    .w               (w),
    .z               (z),
    .busy            (busy),
    .done            (done),
    .pass            (pass),
    .err_count       (err_count),
    .first_err       (first_err),
    .first_err_valid (first_err_valid)
  );

  // The function under test is a plain lookup of the current vector.
  assign s_in = tt[{x, y, w, z}];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Reference result: mismatches are simply the bits where function and table disagree.
  task automatic model(input logic [15:0] f, input logic [15:0] e,
                       output logic m_pass, output logic [4:0] m_cnt,
                       output logic [3:0] m_fe, output logic m_fev);
    logic [15:0] diff;
    diff   = f ^ e;
    m_cnt  = 5'($countones(diff));
    m_pass = (diff == 16'd0);
    m_fev  = (diff != 16'd0);
    m_fe   = 4'd0;
    for (int i = 15; i >= 0; i--) if (diff[i]) m_fe = 4'(i);
  endtask

  // Called at a negedge in IDLE; returns at the negedge of the done cycle (or after the budget).
  task automatic run_sweep(input logic [15:0] f, input logic [15:0] e, input bit hold,
                           input int chg_at, output int cyc, output int dones, output bit vec_ok);
    tt       = f;
    expected = e;
    start    = 1'b1;
    cyc      = 0;
    dones    = 0;
    vec_ok   = 1'b1;
    while (cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1 && !hold) start = 1'b0;
      if (cyc == chg_at) expected = 16'h0000;
      if (done) begin
        dones++;
        break;
      end
      if ({x, y, w, z} !== 4'((cyc - 1) / (SETTLE + 1)) || busy !== 1'b1) vec_ok = 1'b0;
    end
  endtask

  task automatic sweep_and_check(input string tag, input logic [15:0] f, input logic [15:0] e);
    int cyc, dones;
    bit vec_ok;
    logic m_pass, m_fev;
    logic [4:0] m_cnt;
    logic [3:0] m_fe;
    model(f, e, m_pass, m_cnt, m_fe, m_fev);
    run_sweep(f, e, 1'b0, 0, cyc, dones, vec_ok);
    check({tag, " done_cycle"}, 32'(cyc), 32'(DONE_CYCLE));
    check({tag, " vectors"}, {31'd0, vec_ok}, 32'd1);
    check({tag, " result"}, {25'd0, pass, err_count, first_err_valid, first_err},
          {25'd0, m_pass, m_cnt, m_fev, m_fe});
    @(negedge clk);
    check({tag, " idle_hold"}, {23'd0, done, busy, pass, err_count, first_err_valid, first_err},
          {23'd0, 1'b0, 1'b0, m_pass, m_cnt, m_fev, m_fe});
  endtask

  initial begin
    int cyc, dones, guard;
    bit vec_ok;
    bit seen_done;
    logic m_pass, m_fev;
    logic [4:0] m_cnt;
    logic [3:0] m_fe;
    logic [15:0] f, e;

    rst_n    = 1'b0;
    start    = 1'b0;
    expected = 16'h0;
    tt       = 16'h0;

    repeat (3) @(negedge clk);
    check("reset_outputs", {18'd0, x, y, w, z, busy, done, pass, first_err_valid, err_count, first_err}, 32'd0);

    // Release reset and request a sweep in the same cycle: first edge must accept it.
    rst_n = 1'b1;
    sweep_and_check("all_match", 16'hFF00, 16'hFF00);
    sweep_and_check("one_err_v0", 16'hFF00, 16'hFF01);
    sweep_and_check("one_err_v15", 16'h0000, 16'h8000);
    sweep_and_check("all_err", 16'h0000, 16'hFFFF);

    for (int i = 0; i < 6; i++) begin
      f = 16'($urandom);
      e = (i == 0) ? f : (f ^ (16'($urandom) & 16'($urandom) & 16'($urandom)));
      sweep_and_check($sformatf("rand%0d", i), f, e);
    end

    // Start held high throughout; expected cleared mid-sweep must not matter.
    model(16'h5A3C, 16'h5A0C, m_pass, m_cnt, m_fe, m_fev);
    run_sweep(16'h5A3C, 16'h5A0C, 1'b1, 10, cyc, dones, vec_ok);
    check("held done_cycle", 32'(cyc), 32'(DONE_CYCLE));
    check("held result", {25'd0, pass, err_count, first_err_valid, first_err},
          {25'd0, m_pass, m_cnt, m_fev, m_fe});
    @(negedge clk);
    check("held idle_gap", {30'd0, busy, done}, 32'd0);
    @(negedge clk);
    check("held restart", {31'd0, busy}, 32'd1);
    start = 1'b0;
    guard = 0;
    seen_done = 1'b0;
    while (guard < 100 && !seen_done) begin
      @(negedge clk);
      guard++;
      if (done) seen_done = 1'b1;
    end
    check("held second_done", {31'd0, seen_done}, 32'd1);
    model(16'h5A3C, 16'h0000, m_pass, m_cnt, m_fe, m_fev);
    check("held second_result", {25'd0, pass, err_count, first_err_valid, first_err},
          {25'd0, m_pass, m_cnt, m_fev, m_fe});
    @(negedge clk);

    // Abort at idx 7 with an asynchronous reset between edges.
    tt       = 16'h1234;
    expected = 16'hFFFF;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    guard = 0;
    while (guard < 100 && {x, y, w, z} != 4'd7) begin
      @(negedge clk);
      guard++;
    end
    check("abort reached_idx7", {28'd0, x, y, w, z}, 32'd7);
    #2 rst_n = 1'b0;
    #1;
    check("abort outputs_zero", {18'd0, x, y, w, z, busy, done, pass, first_err_valid, err_count, first_err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done || busy) seen_done = 1'b1;
    end
    check("abort no_done", {31'd0, seen_done}, 32'd0);
    sweep_and_check("after_abort", 16'h1234, 16'h1236);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
